// File: rtl/floating_point_accumulator.sv
// floating_point_accumulator
//   Sequential accumulate stage wrapped around an external combinational
//   floating-point adder. It presents {running sum, sample, opcode} to the
//   adder, captures the adder result and feeds it back as the next running sum.
//   Optional feature macro: FP_ACC_SPECIAL_EN. When it is defined, the block
//   adds special_out, a sticky Inf/NaN indicator that freezes the sum.
module floating_point_accumulator #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MENT_WIDTH  = 23,
  parameter int unsigned EXPO_WIDTH  = 8,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   start_in,
  input  logic [COUNT_WIDTH-1:0] length_in,
  input  logic                   sample_valid_in,
  input  logic [DATA_WIDTH-1:0]  sample_in,
  input  logic                   sample_sub_in,
  output logic                   sample_ready_out,
  output logic [DATA_WIDTH-1:0]  adder_a_out,
  output logic [DATA_WIDTH-1:0]  adder_b_out,
  output logic                   adder_opcode_out,
  input  logic [DATA_WIDTH-1:0]  adder_result_in,
  output logic [DATA_WIDTH-1:0]  acc_out,
  output logic [COUNT_WIDTH-1:0] count_out,
  output logic                   busy_out,
`ifdef FP_ACC_SPECIAL_EN
  output logic                   special_out,
`endif
  output logic                   done_out
);

  typedef struct packed {
    logic                  sign;
    logic [EXPO_WIDTH-1:0] expo;
    logic [MENT_WIDTH-1:0] ment;
  } fp_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_ADD,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  fp_t                    acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] len_q, len_d;
  logic [COUNT_WIDTH-1:0] count_inc;
  logic [DATA_WIDTH-1:0]  adder_a_q, adder_a_d;
  logic [DATA_WIDTH-1:0]  adder_b_q, adder_b_d;
  logic                   opcode_q, opcode_d;
  logic                   done_q, done_d;
  logic                   ready;

`ifdef FP_ACC_SPECIAL_EN
  logic special_q, special_d;
  fp_t  sample_fp;

  assign sample_fp = sample_in;
`endif

  // State and datapath registers; async active-low reset clears everything
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      count_q   <= '0;
      len_q     <= '0;
      adder_a_q <= '0;
      adder_b_q <= '0;
      opcode_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef FP_ACC_SPECIAL_EN
      special_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      len_q     <= len_d;
      adder_a_q <= adder_a_d;
      adder_b_q <= adder_b_d;
      opcode_q  <= opcode_d;
      done_q    <= done_d;
`ifdef FP_ACC_SPECIAL_EN
      special_q <= special_d;
`endif
    end
  end

  // Next-state and datapath update; every register holds unless its state acts
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    len_d     = len_q;
    adder_a_d = adder_a_q;
    adder_b_d = adder_b_q;
    opcode_d  = opcode_q;
    done_d    = 1'b0;
    ready     = 1'b0;
    count_inc = count_q + 1'b1;
`ifdef FP_ACC_SPECIAL_EN
    special_d = special_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start_in) begin
          acc_d   = '0;
          count_d = '0;
          len_d   = length_in;
`ifdef FP_ACC_SPECIAL_EN
          special_d = 1'b0;
`endif
          state_d = (length_in == '0) ? S_DONE : S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        ready = 1'b1;
        if (sample_valid_in) begin
          adder_a_d = acc_q;
          adder_b_d = sample_in;
          opcode_d  = sample_sub_in;
          state_d   = S_ADD;
`ifdef FP_ACC_SPECIAL_EN
          // First Inf/NaN sample replaces the sum directly; from then on the sum is frozen
          if (!special_q && (sample_fp.expo == '1)) begin
            special_d = 1'b1;
            acc_d     = sample_in;
          end
`endif
        end
      end
      S_ADD: begin
        // Adder is combinational, so its result is already valid in this cycle
`ifdef FP_ACC_SPECIAL_EN
        if (!special_q) begin
          acc_d = adder_result_in;
        end
`else
        acc_d = adder_result_in;
`endif
        count_d = count_inc;
        state_d = (count_inc == len_q) ? S_DONE : S_ACCEPT;
      end
      S_DONE: begin
        // done is registered so that it appears 2N+1 edges after the start edge
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign sample_ready_out = ready;
  assign busy_out         = (state_q != S_IDLE);
  assign done_out         = done_q;
  assign acc_out          = acc_q;
  assign count_out        = count_q;
  assign adder_a_out      = adder_a_q;
  assign adder_b_out      = adder_b_q;
  assign adder_opcode_out = opcode_q;
`ifdef FP_ACC_SPECIAL_EN
  assign special_out      = special_q;
`endif

endmodule

// File: tb/tb_floating_point_accumulator.sv
// tb_floating_point_accumulator
//   Directed bench for floating_point_accumulator. The external adder is
//   replaced by a lookup stub holding hand-computed IEEE-754 results.
module tb_floating_point_accumulator;

  localparam logic [31:0] S1   = 32'h43876000; // 270.75
  localparam logic [31:0] S2   = 32'h40180000; // 2.375
  localparam logic [31:0] SUM  = 32'h43889000; // 273.125
  localparam logic [31:0] DIFF = 32'h43863000; // 268.375
  localparam logic [31:0] SUM3 = 32'h4389C000; // 275.5

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        start_in = 1'b0;
  logic [7:0]  length_in = '0;
  logic        sample_valid_in = 1'b0;
  logic [31:0] sample_in = '0;
  logic        sample_sub_in = 1'b0;
  logic        sample_ready_out;
  logic [31:0] adder_a_out, adder_b_out, adder_result_in, acc_out;
  logic        adder_opcode_out;
  logic [7:0]  count_out;
  logic        busy_out, done_out;
`ifdef FP_ACC_SPECIAL_EN
  logic        special_out;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int ready_cnt = 0;
  int start_cyc = 0;
  int done_base = 0;

  floating_point_accumulator #(
    .DATA_WIDTH (32),
    .MENT_WIDTH (23),
    .EXPO_WIDTH (8),
    .COUNT_WIDTH(8)
  ) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .start_in        (start_in),
    .length_in       (length_in),
    .sample_valid_in (sample_valid_in),
    .sample_in       (sample_in),
    .sample_sub_in   (sample_sub_in),
    .sample_ready_out(sample_ready_out),
    .adder_a_out     (adder_a_out),
    .adder_b_out     (adder_b_out),
    .adder_opcode_out(adder_opcode_out),
    .adder_result_in (adder_result_in),
    .acc_out         (acc_out),
    .count_out       (count_out),
    .busy_out        (busy_out),
`ifdef FP_ACC_SPECIAL_EN
    .special_out     (special_out),
`endif
    .done_out        (done_out)
  );

  always #5 clk_in = ~clk_in;

  // Adder stub: exact for a zero running sum, table lookup otherwise
  always_comb begin
    adder_result_in = 32'h7FC00001;
    if (adder_a_out == 32'h0)
      adder_result_in = adder_opcode_out ? {~adder_b_out[31], adder_b_out[30:0]} : adder_b_out;
    else if (adder_a_out == S1 && adder_b_out == S2)
      adder_result_in = adder_opcode_out ? DIFF : SUM;
    else if (adder_a_out == SUM && adder_b_out == S2 && !adder_opcode_out)
      adder_result_in = SUM3;
  end

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (done_out) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (sample_ready_out) ready_cnt <= ready_cnt + 1;
  end

  task automatic do_start(input logic [7:0] n);
    done_base = done_cnt;
    start_in  = 1'b1;
    length_in = n;
    @(posedge clk_in); #1;
    start_in  = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic send(input logic [31:0] d, input logic s);
    bit got;
    got = 1'b0;
    sample_valid_in = 1'b1;
    sample_in = d;
    sample_sub_in = s;
    for (int i = 0; i < 40 && !got; i++) begin
      if (sample_ready_out) got = 1'b1;
      @(posedge clk_in); #1;
    end
    sample_valid_in = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL send_timeout: sample %h not accepted (ready=%b) want accept within 40 cycles", d, sample_ready_out);
    end
  endtask

  task automatic wait_done(output int lat);
    bit got;
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clk_in); #1;
      if (done_cnt != done_base) got = 1'b1;
    end
    if (got) lat = done_cyc - start_cyc;
    repeat (3) @(posedge clk_in);
    #1;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL done_timeout: done pulses=%0d want 1", done_cnt - done_base);
    end
    total++;
    if (done_cnt - done_base !== 1) begin
      bad++;
      $display("FAIL done_pulses: got %0d want 1", done_cnt - done_base);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    total++;
    if ({acc_out, adder_a_out, adder_b_out, adder_opcode_out, count_out,
         busy_out, done_out, sample_ready_out} !== '0) begin
      bad++;
      $display("FAIL %s: acc=%h a=%h b=%h op=%b cnt=%0d busy=%b done=%b rdy=%b want all 0",
               tag, acc_out, adder_a_out, adder_b_out, adder_opcode_out, count_out,
               busy_out, done_out, sample_ready_out);
    end
  endtask

  task automatic test_reset();
    #1;
    check_zero_outputs("reset_state");
    repeat (2) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    @(posedge clk_in); #1;
  endtask

  task automatic test_add();
    int lat;
    do_start(8'd2);
    send(S1, 1'b0);
    send(S2, 1'b0);
    wait_done(lat);
    total++;
    if (acc_out !== SUM) begin bad++; $display("FAIL add_acc: got %h want %h", acc_out, SUM); end
    total++;
    if (count_out !== 8'd2) begin bad++; $display("FAIL add_count: got %0d want 2", count_out); end
    total++;
    if (lat !== 5) begin bad++; $display("FAIL add_latency: got %0d want 5", lat); end
    total++;
    if ({adder_a_out, adder_b_out, adder_opcode_out} !== {S1, S2, 1'b0}) begin
      bad++;
      $display("FAIL add_adder_hold: a=%h b=%h op=%b want %h %h 0", adder_a_out, adder_b_out, adder_opcode_out, S1, S2);
    end
    total++;
    if (busy_out !== 1'b0) begin bad++; $display("FAIL add_busy_idle: got %b want 0", busy_out); end
  endtask

  task automatic test_sub();
    int lat;
    do_start(8'd2);
    send(S1, 1'b0);
    send(S2, 1'b1);
    wait_done(lat);
    total++;
    if (acc_out !== DIFF) begin bad++; $display("FAIL sub_acc: got %h want %h", acc_out, DIFF); end
    total++;
    if (adder_opcode_out !== 1'b1) begin bad++; $display("FAIL sub_opcode: got %b want 1", adder_opcode_out); end
  endtask

  task automatic test_zero_length();
    int lat;
    int r0;
    r0 = ready_cnt;
    do_start(8'd0);
    wait_done(lat);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL zero_latency: got %0d want 1", lat); end
    total++;
    if (acc_out !== 32'h0) begin bad++; $display("FAIL zero_acc: got %h want 00000000", acc_out); end
    total++;
    if (count_out !== 8'd0) begin bad++; $display("FAIL zero_count: got %0d want 0", count_out); end
    total++;
    if (ready_cnt !== r0) begin bad++; $display("FAIL zero_ready: ready cycles=%0d want 0", ready_cnt - r0); end
  endtask

  task automatic test_backpressure();
    int lat;
    do_start(8'd3);
    send(S1, 1'b0);
    total++;
    if (sample_ready_out !== 1'b0) begin bad++; $display("FAIL bp_ready_in_add: got %b want 0", sample_ready_out); end
    @(posedge clk_in); #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({sample_ready_out, busy_out, count_out} !== {1'b1, 1'b1, 8'd1}) begin
        bad++;
        $display("FAIL bp_hold_%0d: rdy=%b busy=%b cnt=%0d want 1 1 1", i, sample_ready_out, busy_out, count_out);
      end
      @(posedge clk_in); #1;
    end
    send(S2, 1'b0);
    send(S2, 1'b0);
    wait_done(lat);
    total++;
    if (acc_out !== SUM3) begin bad++; $display("FAIL bp_acc: got %h want %h", acc_out, SUM3); end
    total++;
    if (count_out !== 8'd3) begin bad++; $display("FAIL bp_count: got %0d want 3", count_out); end
  endtask

  task automatic test_busy_start();
    int lat;
    do_start(8'd2);
    send(S1, 1'b0);
    start_in  = 1'b1;
    length_in = 8'd0;
    @(posedge clk_in); #1;
    start_in  = 1'b0;
    send(S2, 1'b0);
    wait_done(lat);
    total++;
    if ({acc_out, count_out} !== {SUM, 8'd2}) begin
      bad++;
      $display("FAIL busy_start: acc=%h cnt=%0d want %h 2", acc_out, count_out, SUM);
    end
  endtask

  task automatic test_reset_mid_add();
    int base;
    do_start(8'd2);
    send(S1, 1'b0);
    base = done_cnt;
    rst_n_in = 1'b0;
    #1;
    check_zero_outputs("reset_mid_add");
    repeat (3) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    repeat (4) @(posedge clk_in);
    #1;
    total++;
    if (done_cnt !== base) begin bad++; $display("FAIL reset_no_done: pulses=%0d want 0", done_cnt - base); end
    test_add();
  endtask

  task automatic test_max_length();
    int lat;
    do_start(8'd255);
    for (int i = 0; i < 255; i++) send(32'h0, 1'b0);
    wait_done(lat);
    total++;
    if (count_out !== 8'd255) begin bad++; $display("FAIL max_count: got %0d want 255", count_out); end
    total++;
    if (lat !== 511) begin bad++; $display("FAIL max_latency: got %0d want 511", lat); end
  endtask

`ifdef FP_ACC_SPECIAL_EN
  task automatic test_special();
    int lat;
    do_start(8'd3);
    send(32'h3F800000, 1'b0);
    send(32'h7F800000, 1'b0);
    send(32'h3F800000, 1'b0);
    wait_done(lat);
    total++;
    if ({special_out, acc_out, count_out} !== {1'b1, 32'h7F800000, 8'd3}) begin
      bad++;
      $display("FAIL special: spec=%b acc=%h cnt=%0d want 1 7f800000 3", special_out, acc_out, count_out);
    end
    do_start(8'd0);
    wait_done(lat);
    total++;
    if (special_out !== 1'b0) begin bad++; $display("FAIL special_clear: got %b want 0", special_out); end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_zero_length();
    test_backpressure();
    test_busy_start();
    test_reset_mid_add();
    test_max_length();
`ifdef FP_ACC_SPECIAL_EN
    test_special();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/floating_point_accumulator.md
Name: floating_point_accumulator

Overview:
Sequential accumulate stage around the existing combinational floating_point_addition block. It consumes a stream of single-precision samples, presents {running sum, sample, opcode} to the adder, captures floating_addition_out, and feeds the result back as the next running sum. The adder is instantiated at the parent level: this block drives the adder's inputs and receives its output, so it sits directly upstream and downstream of it. Used for dot-product and sum reductions.

Parameters:
DATA_WIDTH, 32, total float width
MENT_WIDTH, 23, mantissa width
EXPO_WIDTH, 8, exponent width
COUNT_WIDTH, 8, width of the sample-length and count fields

Ports:
clk_in  input  1  single clock, rising edge
rst_n_in  input  1  reset, asynchronous, active-low
start_in  input  1  pulse: clear the accumulator and latch length_in; honoured only in IDLE
length_in  input  COUNT_WIDTH  number of samples to accumulate
sample_valid_in  input  1  sample handshake valid
sample_in  input  DATA_WIDTH  IEEE-754 sample
sample_sub_in  input  1  0 = add the sample, 1 = subtract it; becomes the adder opcode
sample_ready_out  output  1  sample handshake ready
adder_a_out  output  DATA_WIDTH  registered running sum; connects to adder floating1_in
adder_b_out  output  DATA_WIDTH  registered sample; connects to adder floating2_in
adder_opcode_out  output  1  registered opcode; connects to adder opcode_in
adder_result_in  input  DATA_WIDTH  from adder floating_addition_out
acc_out  output  DATA_WIDTH  current running sum
count_out  output  COUNT_WIDTH  number of samples accumulated so far
busy_out  output  1  high in any state except IDLE
done_out  output  1  one-cycle pulse when the reduction is complete

Behaviour:
- Reset (asynchronous, active-low): state goes to IDLE. All of the following are 0: acc_out, adder_a_out, adder_b_out, adder_opcode_out, count_out, busy_out, done_out, sample_ready_out. The latched length is cleared. Reset asserted mid-operation aborts the reduction with no done_out.
- States: IDLE, ACCEPT, ADD, DONE.
- IDLE:
  - ready = 0.
  - On start_in: acc <= 0, count <= 0, len <= length_in.
  - Next state is DONE if length_in == 0, otherwise ACCEPT.
- ACCEPT:
  - ready = 1.
  - On valid & ready: adder_a <= acc, adder_b <= sample_in, opcode <= sample_sub_in; go to ADD.
  - Without valid, stay in ACCEPT with all outputs held.
- ADD:
  - ready = 0. The adder is combinational, so its result is stable this cycle.
  - acc <= adder_result_in, count <= count + 1.
  - Next state is DONE if count + 1 == len, otherwise ACCEPT.
- DONE: done_out = 1 for exactly one cycle; acc_out holds the final sum; go to IDLE.
- acc_out and count_out hold their values in IDLE until the next start_in.
- start_in while busy is ignored and does not restart the reduction.
- Throughput: one sample per 2 cycles maximum.
- Latency:
  - done_out asserts 2N+1 cycles after the start edge when samples arrive back-to-back.
  - For N = 0, done_out asserts 1 cycle after the start edge.
- count arithmetic is modulo 2^COUNT_WIDTH. length_in = 2^COUNT_WIDTH - 1 completes normally, with no wrap before the compare.
- adder_* outputs hold their last values outside ACCEPT->ADD.

Optional Feature:
Macro FP_ACC_SPECIAL_EN.
- Defined: adds output special_out (1 bit), reset 0 and cleared on start_in.
  - An accepted sample whose exponent is all ones (Inf or NaN) sets special_out sticky and loads acc with that sample directly, bypassing the adder.
  - Later samples are still handshaked and counted, but acc is frozen.
  - done_out timing is unchanged.
- Undefined: the port is absent and every sample passes to the adder unmodified.

Test Plan:
- Add: start with length 2; samples 0x43876000 (270.75, add), then 0x40180000 (2.375, add), back-to-back -> acc_out = 0x43889000 (273.125), count_out = 2, done_out pulses once, 5 cycles after start.
- Subtract: same samples, second with sample_sub_in = 1 -> acc_out = 0x43863000 (268.375).
- Zero length: length 0 -> done_out one cycle after start, acc_out = 0x00000000, sample_ready_out never high.
- Backpressure: length 3, sample_valid_in low for 4 cycles between samples -> state holds in ACCEPT, final sum equals the no-gap result, ready asserts only in ACCEPT.
- Robustness: start_in pulsed while busy -> ignored. rst_n_in dropped mid-ADD -> all outputs 0 immediately, no done_out, and a fresh start works afterwards.
- FP_ACC_SPECIAL_EN: samples 0x3F800000, 0x7F800000, 0x3F800000 -> special_out = 1, acc_out = 0x7F800000, count_out = 3.
